// File: rtl/prefix_arbiter.sv
// prefix_arbiter: round-robin scheduler sharing one prefix-expression evaluator
// between two requesters. It streams the winner's TOKENS-token job into the engine,
// waits for the engine result and returns it tagged with the requester id.
// Optional feature macro: PREFIX_ARB_TIMEOUT_EN adds the WAIT timer and the error response.
module prefix_arbiter #(
    parameter  int unsigned TOKENS  = 19,
    parameter  int unsigned TIMEOUT = 63,
    localparam int unsigned DATA_W  = 5,
    localparam int unsigned RES_W   = 95
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     opt0,
    input  logic                     opt1,
    input  logic [DATA_W-1:0]        data0,
    input  logic [DATA_W-1:0]        data1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     eng_in_valid,
    output logic                     eng_opt,
    output logic [DATA_W-1:0]        eng_in_data,
    input  logic                     eng_out_valid,
    input  logic signed [RES_W-1:0]  eng_out,
    output logic                     rsp_valid,
    output logic                     rsp_id,
    output logic                     rsp_err,
    output logic signed [RES_W-1:0]  rsp_data,
    output logic                     busy
);

    localparam int unsigned CNT_W = (TOKENS > 1) ? $clog2(TOKENS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Reject configurations that cannot stream a job or time out meaningfully.
    if (TOKENS < 2 || TIMEOUT < 1) begin : g_param_chk
        $error("prefix_arbiter: TOKENS must be >= 2 and TIMEOUT >= 1");
    end

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_last_id;
    logic                      r_cur_id;
    logic                      r_gnt0;
    logic                      r_gnt1;
    logic                      r_eng_in_valid;
    logic                      r_eng_opt;
    logic [DATA_W-1:0]         r_eng_in_data;
    logic                      r_rsp_valid;
    logic                      r_rsp_id;
    logic signed [RES_W-1:0]   r_rsp_data;
    logic                      r_busy;

    logic                      w_win_id;
    logic [DATA_W-1:0]         w_data;
    logic                      w_opt;

`ifdef PREFIX_ARB_TIMEOUT_EN
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TMR_W-1:0]          r_timer;
    logic                      r_rsp_err;
`endif

    // Arbitration: a lone request wins; on a tie the side not served last wins.
    assign w_win_id = (req0 && req1) ? ~r_last_id : req1;

    // Token and mode source follow the requester currently holding the grant.
    assign w_data = r_cur_id ? data1 : data0;
    assign w_opt  = r_cur_id ? opt1  : opt0;

    // Scheduler state machine with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_last_id      <= 1'b1;
            r_cur_id       <= 1'b0;
            r_gnt0         <= 1'b0;
            r_gnt1         <= 1'b0;
            r_eng_in_valid <= 1'b0;
            r_eng_opt      <= 1'b0;
            r_eng_in_data  <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= 1'b0;
            r_rsp_data     <= '0;
            r_busy         <= 1'b0;
`ifdef PREFIX_ARB_TIMEOUT_EN
            r_timer        <= '0;
            r_rsp_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_cur_id  <= w_win_id;
                        r_last_id <= w_win_id;
                        r_gnt0    <= ~w_win_id;
                        r_gnt1    <= w_win_id;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_GRANT;
                    end
                end

                S_GRANT: begin
                    r_eng_in_valid <= 1'b1;
                    r_eng_in_data  <= w_data;
                    if (r_cnt == '0) begin
                        r_eng_opt <= w_opt;
                    end
                    if (r_cnt == CNT_W'(TOKENS - 1)) begin
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
`ifdef PREFIX_ARB_TIMEOUT_EN
                        r_timer <= '0;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_WAIT: begin
                    r_eng_in_valid <= 1'b0;
                    // A result on the expiry cycle still wins over the timeout.
                    if (eng_out_valid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_cur_id;
                        r_rsp_data  <= eng_out;
`ifdef PREFIX_ARB_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_state     <= S_RESP;
                    end
`ifdef PREFIX_ARB_TIMEOUT_EN
                    else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_cur_id;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
`endif
                end

                S_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_id    <= 1'b0;
                    r_rsp_data  <= '0;
`ifdef PREFIX_ARB_TIMEOUT_EN
                    r_rsp_err   <= 1'b0;
                    r_timer     <= '0;
`endif
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output drive straight from the registers.
    assign gnt0         = r_gnt0;
    assign gnt1         = r_gnt1;
    assign eng_in_valid = r_eng_in_valid;
    assign eng_opt      = r_eng_opt;
    assign eng_in_data  = r_eng_in_data;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_data     = r_rsp_data;
    assign busy         = r_busy;

`ifdef PREFIX_ARB_TIMEOUT_EN
    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_prefix_arbiter.sv
// tb_prefix_arbiter: randomized job-level bench for prefix_arbiter with a
// transaction model of arbitration order, token stream and response timing.
module tb_prefix_arbiter;

    localparam int unsigned TOKENS  = 19;
    localparam int unsigned TIMEOUT = 63;
`ifdef PREFIX_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               req0, req1, opt0, opt1;
    logic [4:0]         data0, data1;
    logic               gnt0, gnt1, eng_in_valid, eng_opt;
    logic [4:0]         eng_in_data;
    logic               eng_out_valid;
    logic signed [94:0] eng_out;
    logic               rsp_valid, rsp_id, rsp_err, busy;
    logic signed [94:0] rsp_data;

    int n_vec  = 0;
    int n_miss = 0;
    bit m_last;   // model: requester served most recently

    prefix_arbiter #(.TOKENS(TOKENS), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .opt0(opt0), .opt1(opt1),
        .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1),
        .eng_in_valid(eng_in_valid), .eng_opt(eng_opt), .eng_in_data(eng_in_data),
        .eng_out_valid(eng_out_valid), .eng_out(eng_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it when it misses.
    task automatic check(input string tag, input logic [94:0] got, input logic [94:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Run one job from an IDLE negedge through the response and back to IDLE.
    task automatic run_job(input bit r0, input bit r1, input bit opt_v, input logic [4:0] tok0,
                           input int dly, input logic [94:0] result, input bit spur);
        logic [4:0] tok [TOKENS];
        bit  win, seen, err_exp;
        int  g_hi, g_bad, s_bad, w, w_exp;

        for (int k = 0; k < int'(TOKENS); k++) tok[k] = 5'($urandom);
        tok[0] = tok0;
        win    = (r0 && r1) ? ~m_last : r1;
        m_last = win;

        check("idle_busy", 95'(busy), 95'(0));
        req0 = r0; req1 = r1;
        data0 = 5'($urandom); data1 = 5'($urandom);
        opt0 = 1'($urandom); opt1 = 1'($urandom);
        @(negedge clk);
        check("gnt_start", 95'(win ? gnt1 : gnt0), 95'(1));
        check("busy_on", 95'(busy), 95'(1));

        g_hi = 0; g_bad = 0; s_bad = 0;
        for (int k = 0; k < int'(TOKENS); k++) begin
            if (win ? gnt1 : gnt0) g_hi++;
            if (win ? gnt0 : gnt1) g_bad++;
            if (k == 0) begin
                if (eng_in_valid) s_bad++;
            end else if (!eng_in_valid || eng_in_data != tok[k-1] || eng_opt != opt_v) begin
                s_bad++;
            end
            if (rsp_valid) s_bad++;
            data0 = 5'($urandom); data1 = 5'($urandom);
            opt0 = 1'($urandom); opt1 = 1'($urandom);
            if (win) begin
                data1 = tok[k];
                if (k == 0) opt1 = opt_v;
            end else begin
                data0 = tok[k];
                if (k == 0) opt0 = opt_v;
            end
            eng_out_valid = spur && (k == 3);
            eng_out = 95'({$urandom, $urandom, $urandom});
            @(negedge clk);
        end
        // First WAIT cycle: grant gone, last token still presented.
        if (gnt0 || gnt1) g_bad++;
        if (!eng_in_valid || eng_in_data != tok[TOKENS-1] || eng_opt != opt_v) s_bad++;
        check("gnt_len", 95'(g_hi), 95'(TOKENS));
        check("gnt_other", 95'(g_bad), 95'(0));
        check("stream", 95'(s_bad), 95'(0));

        err_exp = TMO_EN && (dly > int'(TIMEOUT) - 1);
        w_exp   = err_exp ? int'(TIMEOUT) - 1 : dly;
        w = 0; seen = 1'b0;
        while (!seen && w <= w_exp + 3) begin
            eng_out_valid = (w == dly);
            eng_out = (w == dly) ? result : 95'({$urandom, $urandom, $urandom});
            @(negedge clk);
            if (w == 0) check("in_valid_fall", 95'(eng_in_valid), 95'(0));
            if (rsp_valid) seen = 1'b1;
            else w++;
        end
        eng_out_valid = 1'b0;
        check("rsp_seen", 95'(seen), 95'(1));
        check("rsp_lat", 95'(w), 95'(w_exp));
        check("rsp_id", 95'(rsp_id), 95'(win));
        check("rsp_err", 95'(rsp_err), 95'(err_exp));
        check("rsp_data", rsp_data, err_exp ? 95'(0) : result);
        check("busy_rsp", 95'(busy), 95'(1));
        @(negedge clk);
        check("rsp_pulse", 95'(rsp_valid), 95'(0));
        check("rsp_data_idle", rsp_data, 95'(0));
        check("busy_off", 95'(busy), 95'(0));
    endtask

    initial begin
        logic [94:0] neg5;
        logic [1:0]  rr;
        int          d;

        rst = 1'b1; req0 = 0; req1 = 0; opt0 = 0; opt1 = 0; data0 = 0; data1 = 0;
        eng_out_valid = 0; eng_out = '0;
        m_last = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outs", 95'({gnt0, gnt1, eng_in_valid, eng_opt, eng_in_data,
                                 rsp_valid, rsp_id, rsp_err, busy}), 95'(0));
        check("reset_data", rsp_data, 95'(0));
        rst = 1'b0;
        @(negedge clk);

        // Tie after reset: expected order 0,1,0.
        for (int j = 0; j < 3; j++) run_job(1, 1, 1'($urandom), 5'($urandom), j, 95'(100 + j), 0);

        // Single job from requester 0, engine answers 42 immediately.
        run_job(1, 0, 0, 5'b10000, 0, 95'sd42, 0);

        // Negative result keeps full signed width.
        neg5 = -95'sd5;
        run_job(0, 1, 1, 5'($urandom), 2, neg5, 0);
        check("neg5_const", neg5, {3'h7, {23{4'hF}}, 4'hB});

        // Spurious result strobe during streaming is ignored.
        run_job(1, 0, 1, 5'($urandom), 4, 95'h1234_5678_9ABC, 1);

        // Long wait: timeout when enabled, result on the expiry cycle otherwise plain success.
        run_job(1, 0, 0, 5'($urandom), TMO_EN ? 1000 : 100, 95'h55, 0);
        run_job(0, 1, 1, 5'($urandom), int'(TIMEOUT) - 1, 95'h77, 0);

        // Reset in the middle of streaming, with cnt at 7.
        req0 = 1; req1 = 0; opt0 = 0; data0 = 5'($urandom);
        @(negedge clk);
        repeat (7) @(negedge clk);
        check("pre_rst_gnt", 95'(gnt0), 95'(1));
        rst = 1'b1;
        #1;
        check("rst_async", 95'({gnt0, gnt1, eng_in_valid, busy, rsp_valid}), 95'(0));
        m_last = 1'b1;
        req0 = 0;
        repeat (3) @(negedge clk);
        check("rst_no_rsp", 95'(rsp_valid), 95'(0));
        rst = 1'b0;
        @(negedge clk);
        run_job(0, 1, 0, 5'($urandom), 1, 95'h9, 0);
        run_job(1, 1, 1, 5'($urandom), 0, 95'h10, 0);

        // Randomized jobs.
        for (int j = 0; j < 16; j++) begin
            rr = 2'($urandom_range(1, 3));
            d  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(0, 6));
            run_job(rr[0], rr[1], 1'($urandom), 5'($urandom), d,
                    95'({$urandom, $urandom, $urandom}), 1'($urandom));
        end

        req0 = 0; req1 = 0;
        repeat (3) @(negedge clk);
        check("final_idle", 95'({busy, gnt0, gnt1, rsp_valid}), 95'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/prefix_arbiter.md
# prefix_arbiter

Round-robin scheduler that shares one prefix-expression evaluator engine between two requesters. It grants one requester at a time and streams that requester's TOKENS-token job into the engine. It then waits for the engine result, with an optional timeout, and returns the result tagged with the requester ID. It sits between the requester front-ends and the evaluator's in_valid/opt/in_data and out_valid/out ports.

## Interface
- TOKENS, 19, tokens per job (grant length)
- TIMEOUT, 63, max WAIT cycles before error response (used only with PREFIX_ARB_TIMEOUT_EN)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0, req1  in  1  job request, sampled only in IDLE
- opt0, opt1  in  1  job mode, sampled on first grant cycle
- data0, data1  in  5  token stream, sampled every grant cycle
- gnt0, gnt1  out  1  registered; high for exactly TOKENS consecutive cycles while streaming
- eng_in_valid  out  1  registered token valid to engine
- eng_opt  out  1  registered; latched job mode, valid whenever eng_in_valid
- eng_in_data  out  5  registered token to engine
- eng_out_valid  in  1  engine result strobe
- eng_out  in  95  signed engine result
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  1  requester served (0/1)
- rsp_err  out  1  1 = timeout, rsp_data = 0
- rsp_data  out  95  signed result; 0 when rsp_valid low
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, GRANT, WAIT, RESP.
- IDLE: when any req is high, arbitrate → GRANT.
  - Single request wins.
  - Both high: the requester other than last_id wins.
  - last_id resets to 1, so req0 wins the first tie.
  - Winner is stored in cur_id; last_id ← cur_id.
- GRANT: gnt[cur_id] high. Token counter cnt (width $clog2(TOKENS)) runs 0..TOKENS-1.
  - Each cycle: eng_in_data ← data[cur_id], eng_in_valid ← 1.
  - On cnt==0: eng_opt ← opt[cur_id].
  - At cnt==TOKENS-1 → WAIT.
- WAIT: timer cleared on entry.
  - eng_out_valid high → capture eng_out, rsp_err=0 → RESP.
  - Else timer increments. timer==TIMEOUT-1 → rsp_err=1, rsp_data=0 → RESP.
  - eng_out_valid in the same cycle as expiry wins (no error).
- RESP: rsp_valid=1 with rsp_id=cur_id for one cycle → IDLE.
- req, opt and data changes outside the sampling points above are ignored.
- eng_out_valid outside WAIT is ignored.
- No back-to-back grants: there is at least one IDLE cycle between jobs.
- Non-selected requester's gnt stays 0 throughout.

## Timing
- Reset values: all outputs 0; state IDLE; cnt 0; timer 0; last_id 1; cur_id 0.
- Reset mid-job aborts immediately: gnt, eng_in_valid and rsp_valid go low asynchronously. No partial response is issued.
- Request to grant: req high at edge E0 in IDLE → gnt high in cycles E0+1 .. E0+TOKENS.
- Engine stream lags gnt by exactly one cycle. eng_in_valid is high TOKENS consecutive cycles, then low. eng_in_valid falls in the first WAIT cycle.
- Response latency: eng_out_valid sampled at edge E → rsp_valid high in cycle E+1, rsp_data = eng_out value at E.
- Timeout: WAIT lasts at most TIMEOUT cycles. rsp_valid (err) is high in cycle TIMEOUT+1 after WAIT entry.
- Tie arbitration alternates strictly when both requesters hold req continuously.

## Configuration
- PREFIX_ARB_TIMEOUT_EN defined: timer and error path implemented as above.
- Not defined: no timer. WAIT waits indefinitely for eng_out_valid, rsp_err is tied 0, and TIMEOUT is unused.

## Test plan
- Single job: req0=1, opt0=0, stream of 19 tokens (first token 5'b10000).
  - gnt0 high 19 cycles; eng_in_valid high 19 cycles, one cycle delayed.
  - Engine model returns 95'sd42 → rsp_valid=1, rsp_id=0, rsp_err=0, rsp_data=42, one cycle later.
- Tie after reset: req0=req1=1 held.
  - Grants in order 0,1,0. Each rsp_id matches its grant. gnt0 and gnt1 are never simultaneously high.
- Negative result: engine returns −5 → rsp_data = 95'h7FFF…FFFB, sign-correct, no truncation.
- Timeout (macro on, TIMEOUT=63): engine never responds.
  - rsp_valid=1, rsp_err=1, rsp_data=0 at 64th cycle after WAIT entry; busy falls next cycle.
  - Repeat with eng_out_valid on the expiry cycle → rsp_err=0.
- Reset mid-GRANT: assert rst at cnt=7.
  - gnt, eng_in_valid and busy drop to 0 immediately; no rsp_valid.
  - After release, req1 alone is granted normally.
- Spurious eng_out_valid during GRANT: ignored. The response carries the value presented in WAIT.
